// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard-flag inputs, pipeline controls and counters for pipe_hazard_ctrl
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   // hazard detector / EX-stage inputs
   logic             stall;
   logic             alu_a_ex;
   logic             alu_a_mem;
   logic             alu_b_ex;
   logic             alu_b_mem;
   logic             rt_ex;
   logic             rt_mem;
   logic             src1_ex;
   logic             src1_mem;
   logic             branch_taken;
   logic             halt;
   logic             go;

   // pipeline controls
   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic [1:0]       fwd_rt_sel;
   logic [1:0]       fwd_s1_sel;

   // status and performance counters
   logic             halted;
   logic             stall_err;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output stall, alu_a_ex, alu_a_mem, alu_b_ex, alu_b_mem,
             rt_ex, rt_mem, src1_ex, src1_mem, branch_taken, halt, go,
      input  pc_en, ifid_en, ifid_flush, idex_flush,
             fwd_a_sel, fwd_b_sel, fwd_rt_sel, fwd_s1_sel,
             halted, stall_err, cycle_cnt, stall_cnt, flush_cnt
   );

   modport slave (
      input  stall, alu_a_ex, alu_a_mem, alu_b_ex, alu_b_mem,
             rt_ex, rt_mem, src1_ex, src1_mem, branch_taken, halt, go,
      output pc_en, ifid_en, ifid_flush, idex_flush,
             fwd_a_sel, fwd_b_sel, fwd_rt_sel, fwd_s1_sel,
             halted, stall_err, cycle_cnt, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/forwarding control with RUN/HALT sequencer and counters
module pipe_hazard_ctrl #(
   parameter int CNT_W     = 32,
   parameter int MAX_STALL = 4
) (
   input  logic             clk,
   input  logic             rst,
   pipe_hazard_ctrl_if.slave bus
);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   // run-length counter only needs to reach MAX_STALL+1, where it parks
   localparam int              RL_W    = $clog2(MAX_STALL + 2);
   localparam logic [RL_W-1:0] RL_TRIP = RL_W'(MAX_STALL + 1);
   localparam logic [RL_W-1:0] RL_PRE  = RL_W'(MAX_STALL);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   state_t           state_nxt;
   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             running;
   logic             stall_run;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic [1:0]       fwd_rt_sel;
   logic [1:0]       fwd_s1_sel;
   logic             stall_err;
   logic [RL_W-1:0]  run_len;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // EX result is newer than MEM/WB, so it wins when both match
   function automatic logic [1:0] pick_src(input logic ex_hit, input logic mem_hit);
      if (ex_hit)
         return 2'b01;
      else if (mem_hit)
         return 2'b10;
      else
         return 2'b00;
   endfunction

   // sequencer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= RUN;
      else
         state <= state_nxt;
   end

   // next state and same-cycle pipeline controls
   always_comb begin
      state_nxt  = state;
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      case (state)
         RUN: begin
            if (bus.branch_taken) begin
               pc_en      = 1'b1;
               ifid_en    = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (bus.stall) begin
               idex_flush = 1'b1;
            end else begin
               pc_en   = 1'b1;
               ifid_en = 1'b1;
            end
            if (bus.halt)
               state_nxt = HALT;
         end
         HALT: begin
            if (bus.go)
               state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   assign running   = (state == RUN);
   assign stall_run = running && bus.stall && !bus.branch_taken;

   // forwarding selects for the instruction entering EX; a bubble forwards nothing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_a_sel  <= 2'b00;
         fwd_b_sel  <= 2'b00;
         fwd_rt_sel <= 2'b00;
         fwd_s1_sel <= 2'b00;
      end else if (running) begin
         if (idex_flush) begin
            fwd_a_sel  <= 2'b00;
            fwd_b_sel  <= 2'b00;
            fwd_rt_sel <= 2'b00;
            fwd_s1_sel <= 2'b00;
         end else begin
            fwd_a_sel  <= pick_src(bus.alu_a_ex, bus.alu_a_mem);
            fwd_b_sel  <= pick_src(bus.alu_b_ex, bus.alu_b_mem);
            fwd_rt_sel <= pick_src(bus.rt_ex, bus.rt_mem);
            fwd_s1_sel <= pick_src(bus.src1_ex, bus.src1_mem);
         end
      end
   end

   // stall watchdog: consecutive stall cycles, sticky error once the limit is exceeded
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_len   <= '0;
         stall_err <= 1'b0;
      end else if (stall_run) begin
         if (run_len != RL_TRIP)
            run_len <= run_len + 1'b1;
         if (run_len >= RL_PRE)
            stall_err <= 1'b1;
      end else begin
         run_len <= '0;
      end
   end

   // saturating performance counters, frozen while halted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (running) begin
         if (cycle_cnt != CNT_MAX)
            cycle_cnt <= cycle_cnt + 1'b1;
         if (bus.branch_taken) begin
            if (flush_cnt != CNT_MAX)
               flush_cnt <= flush_cnt + 1'b1;
         end else if (bus.stall) begin
            if (stall_cnt != CNT_MAX)
               stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

   assign bus.pc_en      = pc_en;
   assign bus.ifid_en    = ifid_en;
   assign bus.ifid_flush = ifid_flush;
   assign bus.idex_flush = idex_flush;
   assign bus.fwd_a_sel  = fwd_a_sel;
   assign bus.fwd_b_sel  = fwd_b_sel;
   assign bus.fwd_rt_sel = fwd_rt_sel;
   assign bus.fwd_s1_sel = fwd_s1_sel;
   assign bus.halted     = (state == HALT);
   assign bus.stall_err  = stall_err;
   assign bus.cycle_cnt  = cycle_cnt;
   assign bus.stall_cnt  = stall_cnt;
   assign bus.flush_cnt  = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl (32-bit and 4-bit counter instances)
module tb_pipe_hazard_ctrl;

   logic clk;
   logic rst;

   pipe_hazard_ctrl_if #(.CNT_W(32)) bus_w ();
   pipe_hazard_ctrl_if #(.CNT_W(4))  bus_n ();

   pipe_hazard_ctrl #(.CNT_W(32), .MAX_STALL(4)) dut_w (.clk(clk), .rst(rst), .bus(bus_w.slave));
   pipe_hazard_ctrl #(.CNT_W(4),  .MAX_STALL(4)) dut_n (.clk(clk), .rst(rst), .bus(bus_n.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   // reference model state
   bit       m_halted;
   bit [1:0] m_sel [4];
   longint   m_cyc;
   longint   m_stl;
   longint   m_fl;
   bit       m_err;
   int       m_run;

   // current stimulus
   bit       s_stall, s_br, s_halt, s_go;
   bit [7:0] s_flags;

   function automatic longint sat(input longint v, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_halted = 0;
      for (int i = 0; i < 4; i++) m_sel[i] = 2'b00;
      m_cyc = 0; m_stl = 0; m_fl = 0; m_err = 0; m_run = 0;
   endtask

   task automatic drive();
      bus_w.stall = s_stall;        bus_n.stall = s_stall;
      bus_w.branch_taken = s_br;    bus_n.branch_taken = s_br;
      bus_w.halt = s_halt;          bus_n.halt = s_halt;
      bus_w.go = s_go;              bus_n.go = s_go;
      bus_w.alu_a_ex  = s_flags[0]; bus_n.alu_a_ex  = s_flags[0];
      bus_w.alu_a_mem = s_flags[1]; bus_n.alu_a_mem = s_flags[1];
      bus_w.alu_b_ex  = s_flags[2]; bus_n.alu_b_ex  = s_flags[2];
      bus_w.alu_b_mem = s_flags[3]; bus_n.alu_b_mem = s_flags[3];
      bus_w.rt_ex     = s_flags[4]; bus_n.rt_ex     = s_flags[4];
      bus_w.rt_mem    = s_flags[5]; bus_n.rt_mem    = s_flags[5];
      bus_w.src1_ex   = s_flags[6]; bus_n.src1_ex   = s_flags[6];
      bus_w.src1_mem  = s_flags[7]; bus_n.src1_mem  = s_flags[7];
   endtask

   task automatic check_comb();
      bit e_pc, e_ifen, e_iff, e_idf;
      if (m_halted) begin
         e_pc = 0; e_ifen = 0; e_iff = 0; e_idf = 0;
      end else if (s_br) begin
         e_pc = 1; e_ifen = 1; e_iff = 1; e_idf = 1;
      end else if (s_stall) begin
         e_pc = 0; e_ifen = 0; e_iff = 0; e_idf = 1;
      end else begin
         e_pc = 1; e_ifen = 1; e_iff = 0; e_idf = 0;
      end
      chk("pc_en",      bus_w.pc_en,      e_pc);
      chk("ifid_en",    bus_w.ifid_en,    e_ifen);
      chk("ifid_flush", bus_w.ifid_flush, e_iff);
      chk("idex_flush", bus_w.idex_flush, e_idf);
      chk("n_pc_en",    bus_n.pc_en,      e_pc);
      chk("n_idex_flush", bus_n.idex_flush, e_idf);
   endtask

   task automatic check_regs();
      chk("halted",     bus_w.halted,     m_halted);
      chk("fwd_a_sel",  bus_w.fwd_a_sel,  m_sel[0]);
      chk("fwd_b_sel",  bus_w.fwd_b_sel,  m_sel[1]);
      chk("fwd_rt_sel", bus_w.fwd_rt_sel, m_sel[2]);
      chk("fwd_s1_sel", bus_w.fwd_s1_sel, m_sel[3]);
      chk("stall_err",  bus_w.stall_err,  m_err);
      chk("cycle_cnt",  bus_w.cycle_cnt,  sat(m_cyc, 32));
      chk("stall_cnt",  bus_w.stall_cnt,  sat(m_stl, 32));
      chk("flush_cnt",  bus_w.flush_cnt,  sat(m_fl, 32));
      chk("n_halted",    bus_n.halted,    m_halted);
      chk("n_stall_err", bus_n.stall_err, m_err);
      chk("n_cycle_cnt", bus_n.cycle_cnt, sat(m_cyc, 4));
      chk("n_stall_cnt", bus_n.stall_cnt, sat(m_stl, 4));
      chk("n_flush_cnt", bus_n.flush_cnt, sat(m_fl, 4));
   endtask

   // apply one cycle of stimulus, check controls before the edge and state after it
   task automatic step(input bit st, input bit br, input bit h, input bit g, input bit [7:0] fl);
      bit flush;
      s_stall = st; s_br = br; s_halt = h; s_go = g; s_flags = fl;
      drive();
      #2;
      check_comb();
      @(posedge clk);
      if (!m_halted) begin
         flush = br | st;
         m_cyc++;
         if (br) m_fl++;
         else if (st) m_stl++;
         for (int i = 0; i < 4; i++)
            m_sel[i] = flush ? 2'b00 : (fl[2*i] ? 2'b01 : (fl[2*i+1] ? 2'b10 : 2'b00));
         m_run = (st && !br) ? m_run + 1 : 0;
         if (m_run > 4) m_err = 1;
         if (h) m_halted = 1;
      end else begin
         m_run = 0;
         if (g) m_halted = 0;
      end
      #1;
      check_regs();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      s_stall = 0; s_br = 0; s_halt = 0; s_go = 0; s_flags = 8'h00;
      drive();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_regs();
      rst = 1'b0;

      // single stall cycle
      step(0, 0, 0, 0, 8'h00);
      step(1, 0, 0, 0, 8'hFF);
      chk("stall_cnt_one", bus_w.stall_cnt, 64'd1);

      // forwarding priority: a_ex + a_mem -> 01, rt_mem -> 10, b idle -> 00
      step(0, 0, 0, 0, 8'b0010_0011);
      chk("fwd_a_ex_wins", bus_w.fwd_a_sel, 64'd1);
      chk("fwd_rt_mem",    bus_w.fwd_rt_sel, 64'd2);

      // branch beats stall
      step(1, 1, 0, 0, 8'h55);
      chk("flush_cnt_one", bus_w.flush_cnt, 64'd1);

      // halt for 10 cycles, then go
      step(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 8'($urandom));
      step(0, 0, 1, 1, 8'h00);
      step(0, 0, 0, 1, 8'h0A);
      step(0, 0, 0, 0, 8'hA0);

      // stall held 5 cycles trips the watchdog, which stays set
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'h00);
      chk("stall_err_set", bus_w.stall_err, 64'd1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'h00);

      // enough run cycles to saturate the 4-bit counters
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 8'($urandom));
      chk("n_cycle_sat", bus_n.cycle_cnt, 64'd15);

      // asynchronous reset mid-cycle, while halted
      step(0, 0, 1, 0, 8'h00);
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      check_regs();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 3) == 0, ($urandom % 8) == 0, ($urandom % 20) == 0,
              ($urandom % 4) == 0, 8'($urandom));
      end

      // async reset from RUN after random traffic
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      check_regs();
      s_stall = 0; s_br = 0; s_halt = 0; s_go = 0; s_flags = 8'h00;
      drive();
      #1;
      check_comb();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(0, 0, 0, 0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
